id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
ID/EX pipeline register of the 5-stage RV32I core, plus EX-side operand forwarding and load-use hazard detection. Captures decoded instruction fields from ID and presents final ALU operands (A, B) and the 4-bit ALU control code to the EX-stage ALU. It also provides the forwarded store data and control bits to EX/MEM. Owns the decision to bubble EX on a load-use hazard and signals ID/IF to hold.

Parameters:
XLEN, 32, datapath width
RADDR_W, 5, register address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
stall  in  1  downstream hold (memory wait); freezes this register
flush  in  1  branch/jump redirect; converts captured slot to bubble
id_valid  in  1  ID slot holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1_addr, id_rs2_addr, id_rd_addr  in  RADDR_W  register indices
id_alu_ctrl  in  4  ALU code (0000 ADD … 1001 SLTU)
id_a_sel  in  1  0=rs1, 1=PC
id_b_sel  in  1  0=rs2, 1=imm
id_reg_write, id_mem_read, id_mem_write  in  1  control bits
exmem_reg_write  in  1 ; exmem_rd_addr  in  RADDR_W ; exmem_result  in  XLEN  EX/MEM forward source
memwb_reg_write  in  1 ; memwb_rd_addr  in  RADDR_W ; memwb_result  in  XLEN  MEM/WB forward source
load_use_stall  out  1  hold PC and IF/ID this cycle
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
ex_pc  out  XLEN ; ex_rd_addr  out  RADDR_W
alu_a, alu_b  out  XLEN  ALU operands
alu_ctrl  out  4  ALU code
ex_store_data  out  XLEN  forwarded rs2 for stores

Behaviour:
- Register update priority on each rising clk: rst > flush > stall > load_use_stall > normal load.
- rst and flush load a bubble: valid, reg_write, mem_read and mem_write = 0; rd/rs addrs = 0; alu_ctrl = 0000; pc, data, imm and sel bits = 0. All outputs read 0 after reset.
- stall: all registers hold their value. flush with stall asserted in the same cycle still loads a bubble.
- Normal load: all id_* fields are captured. Latency is 1 cycle from ID to EX outputs.
- Same-cycle WB bypass on capture: if memwb_reg_write, memwb_rd_addr≠0 and memwb_rd_addr equals id_rs1_addr (or id_rs2_addr), capture memwb_result instead of the register-file data for that operand.
- load_use_stall (combinational) = id_valid & ex_valid & ex_mem_read & ex_rd_addr≠0 & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr). When asserted and neither stall nor flush is active, the register loads a bubble. The ID instruction is re-presented next cycle.
- Forwarding (combinational, on registered rs addrs):
  - fwd_rs1 = exmem_result if exmem_reg_write & exmem_rd_addr≠0 & exmem_rd_addr==ex_rs1_addr.
  - Else memwb_result under the same conditions on the MEM/WB signals.
  - Else the registered rs1 data.
  - EX/MEM takes priority over MEM/WB. fwd_rs2 is formed the same way.
- Address x0 is never forwarded. Registered data for x0 passes through unchanged.
- alu_a = a_sel ? ex_pc : fwd_rs1. alu_b = b_sel ? ex_imm : fwd_rs2. ex_store_data = fwd_rs2 regardless of b_sel.
- alu_ctrl passes through the register unmodified. Codes outside 0000–1001 are passed as-is; the ALU defines their result.
- Bubble slots forward nothing downstream (reg_write=0), so they never become forwarding sources.

Test Plan:
- Reset: assert rst with all inputs nonzero for 1 cycle → every output is 0, including alu_ctrl=0000 and load_use_stall=0.
- Basic load: id_rs1_data=5, id_rs2_data=7, alu_ctrl=0000, sels=0, no forward matches → next cycle alu_a=5, alu_b=7, alu_ctrl=0000.
- Forward priority: ex_rs1=x3; exmem rd=3, result=0x11; memwb rd=3, result=0x22; both write enabled → alu_a=0x11. Drop exmem_reg_write → alu_a=0x22. Set rd=0 on both → alu_a = registered data.
- Load-use: EX holds lw to x4 (mem_read=1); ID presents add with rs2=x4 → load_use_stall=1, next cycle ex_valid=0 and ex_reg_write=0. Same ID instruction next cycle with EX now a bubble → load_use_stall=0 and the instruction is captured.
- Stall/flush: stall=1 for 3 cycles with changing id_* → outputs frozen. stall=1 and flush=1 together → bubble loaded.
- WB bypass and immediate select: memwb rd=6, result=0xDEAD, write enabled; id_rs1_addr=6, id_rs1_data=0 → alu_a=0xDEAD next cycle. With b_sel=1, imm=0xFFFFFFFC → alu_b=0xFFFFFFFC while ex_store_data still equals the forwarded rs2.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use hazard detection.
// Produces the final ALU operands, ALU code and forwarded store data for the EX stage.
module id_ex_operand_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [RADDR_W-1:0] id_rs1_addr,
  input  logic [RADDR_W-1:0] id_rs2_addr,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic [3:0]         id_alu_ctrl,
  input  logic               id_a_sel,
  input  logic               id_b_sel,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0]    memwb_result,
  output logic               load_use_stall,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [XLEN-1:0]    ex_pc,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [3:0]         alu_ctrl,
  output logic [XLEN-1:0]    ex_store_data
);

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               a_sel;
    logic               b_sel;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic [RADDR_W-1:0] rd_addr;
    logic [3:0]         alu_ctrl;
  } slot_t;

  slot_t ex_q;
  slot_t id_d;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // A source register matches a producer only if that producer writes a non-x0 register.
  function automatic logic hit(input logic               wr,
                               input logic [RADDR_W-1:0] rd,
                               input logic [RADDR_W-1:0] rs);
    return wr && (rd != '0) && (rd == rs);
  endfunction

  always_comb begin
    id_d           = '0;
    id_d.valid     = id_valid;
    id_d.reg_write = id_reg_write;
    id_d.mem_read  = id_mem_read;
    id_d.mem_write = id_mem_write;
    id_d.a_sel     = id_a_sel;
    id_d.b_sel     = id_b_sel;
    id_d.pc        = id_pc;
    id_d.imm       = id_imm;
    id_d.rs1_addr  = id_rs1_addr;
    id_d.rs2_addr  = id_rs2_addr;
    id_d.rd_addr   = id_rd_addr;
    id_d.alu_ctrl  = id_alu_ctrl;
    // The register file is written at the end of this cycle, so take the WB value directly.
    id_d.rs1_data  = hit(memwb_reg_write, memwb_rd_addr, id_rs1_addr) ? memwb_result : id_rs1_data;
    id_d.rs2_data  = hit(memwb_reg_write, memwb_rd_addr, id_rs2_addr) ? memwb_result : id_rs2_data;
  end

  assign load_use_stall = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) &&
                          ((ex_q.rd_addr == id_rs1_addr) || (ex_q.rd_addr == id_rs2_addr));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_q <= '0;
    end else if (!stall) begin
      ex_q <= load_use_stall ? '0 : id_d;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    if (hit(exmem_reg_write, exmem_rd_addr, ex_q.rs1_addr)) begin
      fwd_rs1 = exmem_result;
    end else if (hit(memwb_reg_write, memwb_rd_addr, ex_q.rs1_addr)) begin
      fwd_rs1 = memwb_result;
    end
    fwd_rs2 = ex_q.rs2_data;
    if (hit(exmem_reg_write, exmem_rd_addr, ex_q.rs2_addr)) begin
      fwd_rs2 = exmem_result;
    end else if (hit(memwb_reg_write, memwb_rd_addr, ex_q.rs2_addr)) begin
      fwd_rs2 = memwb_result;
    end
  end

  assign alu_a         = ex_q.a_sel ? ex_q.pc  : fwd_rs1;
  assign alu_b         = ex_q.b_sel ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_ctrl      = ex_q.alu_ctrl;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_pc         = ex_q.pc;
  assign ex_rd_addr    = ex_q.rd_addr;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed testbench for id_ex_operand_stage: reset, capture, forwarding priority,
// load-use bubbling, stall/flush and WB bypass with immediate select.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_ctrl;
  logic        id_a_sel, id_b_sel, id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_result, memwb_result;
  logic        load_use_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic [3:0]  alu_ctrl;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_ctrl(id_alu_ctrl), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic [4:0] rs1a, input logic [31:0] rs1d,
                               input logic [4:0] rs2a, input logic [31:0] rs2d,
                               input logic [4:0] rda, input logic [31:0] imm, input logic [3:0] ctrl,
                               input logic asel, input logic bsel,
                               input logic rw, input logic mr, input logic mw);
    id_valid = valid; id_pc = pc;
    id_rs1_addr = rs1a; id_rs1_data = rs1d;
    id_rs2_addr = rs2a; id_rs2_data = rs2d;
    id_rd_addr = rda; id_imm = imm; id_alu_ctrl = ctrl;
    id_a_sel = asel; id_b_sel = bsel;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with every input driven nonzero
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    applyStimulus(1'b1, 32'h1234, 5'd1, 32'hAAAA, 5'd2, 32'hBBBB, 5'd3, 32'hCCCC, 4'h7,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd9; exmem_result = 32'h99;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd10; memwb_result = 32'h1010;
    step();
    checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("rst_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    checkOutput("rst_ex_mem_read", {31'd0, ex_mem_read}, 32'd0);
    checkOutput("rst_ex_mem_write", {31'd0, ex_mem_write}, 32'd0);
    checkOutput("rst_ex_pc", ex_pc, 32'd0);
    checkOutput("rst_ex_rd_addr", {27'd0, ex_rd_addr}, 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    checkOutput("rst_store_data", ex_store_data, 32'd0);
    checkOutput("rst_load_use", {31'd0, load_use_stall}, 32'd0);

    // Basic capture, no forwarding sources active
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    applyStimulus(1'b1, 32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0, 4'h0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("basic_alu_a", alu_a, 32'd5);
    checkOutput("basic_alu_b", alu_b, 32'd7);
    checkOutput("basic_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    checkOutput("basic_ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("basic_ex_pc", ex_pc, 32'h100);
    checkOutput("basic_ex_rd", {27'd0, ex_rd_addr}, 32'd3);

    // Forwarding priority on rs1 = x3; out-of-range ALU code passes through
    applyStimulus(1'b1, 32'h104, 5'd3, 32'h33, 5'd5, 32'h55, 5'd6, 32'd0, 4'hF,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("ctrl_passthrough", {28'd0, alu_ctrl}, 32'hF);
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd3; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd3; memwb_result = 32'h22;
    #1;
    checkOutput("fwd_exmem_priority", alu_a, 32'h11);
    checkOutput("fwd_rs2_untouched", alu_b, 32'h55);
    exmem_reg_write = 1'b0;
    #1;
    checkOutput("fwd_memwb", alu_a, 32'h22);
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd0; memwb_rd_addr = 5'd0;
    #1;
    checkOutput("fwd_x0_none", alu_a, 32'h33);
    exmem_rd_addr = 5'd5; exmem_result = 32'h77;
    #1;
    checkOutput("fwd_rs2_alu_b", alu_b, 32'h77);
    checkOutput("fwd_rs2_store", ex_store_data, 32'h77);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

    // Load-use: lw x4 in EX, add using x4 in ID
    applyStimulus(1'b1, 32'h200, 5'd1, 32'h1000, 5'd0, 32'd0, 5'd4, 32'd8, 4'h0,
                  1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("lw_mem_read", {31'd0, ex_mem_read}, 32'd1);
    checkOutput("lw_alu_b_imm", alu_b, 32'd8);
    applyStimulus(1'b1, 32'h204, 5'd2, 32'hA, 5'd4, 32'hB, 5'd5, 32'd0, 4'h0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("lu_stall_high", {31'd0, load_use_stall}, 32'd1);
    step();
    checkOutput("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
    checkOutput("lu_stall_released", {31'd0, load_use_stall}, 32'd0);
    step();
    checkOutput("lu_capture_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("lu_capture_rd", {27'd0, ex_rd_addr}, 32'd5);
    checkOutput("lu_capture_alu_a", alu_a, 32'hA);

    // Stall for 3 cycles with changing ID inputs
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(i * 4), 5'd7, 32'h70 + 32'(i), 5'd8, 32'h80, 5'd9 + 5'(i),
                    32'd1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
      checkOutput("stall_pc", ex_pc, 32'h204);
      checkOutput("stall_alu_a", alu_a, 32'hA);
      checkOutput("stall_mem_write", {31'd0, ex_mem_write}, 32'd0);
    end
    flush = 1'b1;
    step();
    checkOutput("stall_flush_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("stall_flush_pc", ex_pc, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // WB bypass on capture, immediate select and store data
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd6; memwb_result = 32'hDEAD;
    applyStimulus(1'b1, 32'h400, 5'd6, 32'd0, 5'd7, 32'h1234, 5'd8, 32'hFFFF_FFFC, 4'h1,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    memwb_reg_write = 1'b0;
    #1;
    checkOutput("wb_bypass_alu_a", alu_a, 32'hDEAD);
    checkOutput("imm_alu_b", alu_b, 32'hFFFF_FFFC);
    checkOutput("store_data_rs2", ex_store_data, 32'h1234);
    checkOutput("store_mem_write", {31'd0, ex_mem_write}, 32'd1);
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd7; exmem_result = 32'hBEEF;
    #1;
    checkOutput("store_data_fwd", ex_store_data, 32'hBEEF);
    checkOutput("imm_alu_b_kept", alu_b, 32'hFFFF_FFFC);
    exmem_reg_write = 1'b0;

    // PC select on operand A, then a plain flush
    applyStimulus(1'b1, 32'h500, 5'd1, 32'h55, 5'd2, 32'h66, 5'd3, 32'd0, 4'h0,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("pc_sel_alu_a", alu_a, 32'h500);
    flush = 1'b1;
    step();
    checkOutput("flush_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flush_rw", {31'd0, ex_reg_write}, 32'd0);
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
